// File: rtl/md5_msg_driver.sv
// Message-side driver for the pancham MD5 core: packs a byte stream, issues one request, captures the digest.
// Optional digest comparator built when MD5_DRV_COMPARE_EN is defined.
module md5_msg_driver #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_last,
  input  logic         byte_empty,
  output logic         byte_ready,
  input  logic         core_ready,
  output logic [0:127] msg_in,
  output logic [0:7]   msg_in_width,
  output logic         msg_in_valid,
  input  logic [0:127] msg_output,
  input  logic         msg_out_valid,
  input  logic [0:127] target_digest,
  output logic [0:127] digest,
  output logic         digest_valid,
  output logic         match,
  output logic         len_err,
  output logic         timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT_DIG
  } state_e;

  localparam logic [16:0] WLIM = 17'(WAIT_LIMIT);

  state_e         state_q, state_d;
  logic [0:127]   buf_q, buf_d;
  logic [4:0]     count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    wcnt_q, wcnt_d;
  logic [16:0]    wcnt_next;
  logic [0:127]   msg_q, msg_d;
  logic [0:7]     width_q, width_d;
  logic           issue_q, issue_d;
  logic           ready_q, ready_d;
  logic [0:127]   digest_q, digest_d;
  logic           dvalid_q, dvalid_d;
  logic           match_q, match_d;
  logic           len_err_q, len_err_d;
  logic           timeout_q, timeout_d;

  logic [0:127]   pk_buf;
  logic [4:0]     pk_cnt;
  logic           ovf_hit;
  logic           has_data;
  logic           digest_eq;

`ifdef MD5_DRV_COMPARE_EN
  assign digest_eq = (msg_output == target_digest);
`else
  logic unused_target;
  assign unused_target = ^target_digest;
  assign digest_eq     = 1'b0;
`endif

  // An empty-flagged last beat is the only beat that carries no byte.
  assign has_data  = ~(byte_last & byte_empty);
  assign wcnt_next = {1'b0, wcnt_q} + 17'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    buf_d     = buf_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    wcnt_d    = wcnt_q;
    msg_d     = msg_q;
    width_d   = width_q;
    digest_d  = digest_q;
    dvalid_d  = 1'b0;
    match_d   = 1'b0;
    len_err_d = 1'b0;
    timeout_d = 1'b0;
    pk_buf    = buf_q;
    pk_cnt    = count_q;
    ovf_hit   = ovf_q;

    case (state_q)
      S_IDLE: state_d = S_COLLECT;

      S_COLLECT: begin
        if (byte_valid) begin
          if (has_data) begin
            if (count_q == 5'd16) begin
              ovf_hit = 1'b1;
            end else begin
              pk_buf = {buf_q[8:127], byte_in};
              pk_cnt = count_q + 5'd1;
            end
          end
          if (byte_last) begin
            buf_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            if (ovf_hit) begin
              len_err_d = 1'b1;
            end else begin
              state_d = S_WAIT_RDY;
              msg_d   = pk_buf;
              width_d = {pk_cnt, 3'b000};
            end
          end else begin
            buf_d   = pk_buf;
            count_d = pk_cnt;
            ovf_d   = ovf_hit;
          end
        end
      end

      S_WAIT_RDY: begin
        if (core_ready) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        state_d = S_WAIT_DIG;
        wcnt_d  = '0;
      end

      S_WAIT_DIG: begin
        // A digest arriving on the limit cycle takes priority over the timeout.
        if (msg_out_valid) begin
          digest_d = msg_output;
          dvalid_d = 1'b1;
          match_d  = digest_eq;
          state_d  = S_COLLECT;
          msg_d    = '0;
          width_d  = '0;
        end else if (wcnt_next == WLIM) begin
          timeout_d = 1'b1;
          state_d   = S_COLLECT;
          msg_d     = '0;
          width_d   = '0;
        end else begin
          wcnt_d = wcnt_next[15:0];
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_COLLECT);
    issue_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      wcnt_q    <= '0;
      msg_q     <= '0;
      width_q   <= '0;
      issue_q   <= 1'b0;
      ready_q   <= 1'b0;
      digest_q  <= '0;
      dvalid_q  <= 1'b0;
      match_q   <= 1'b0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      wcnt_q    <= wcnt_d;
      msg_q     <= msg_d;
      width_q   <= width_d;
      issue_q   <= issue_d;
      ready_q   <= ready_d;
      digest_q  <= digest_d;
      dvalid_q  <= dvalid_d;
      match_q   <= match_d;
      len_err_q <= len_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign byte_ready   = ready_q;
  assign msg_in       = msg_q;
  assign msg_in_width = width_q;
  assign msg_in_valid = issue_q;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign match        = match_q;
  assign len_err      = len_err_q;
  assign timeout      = timeout_q;

endmodule
